qspi_rx_deser: RTL and testbench

- Parametrised receive deserialiser for the QSPI controller.
- Assembles DATA_W-bit words from the SD lines in single (x1), dual (x2) or quad (x4) lane mode, MSB-first or LSB-first.
- Sits between the SCK-edge sampling logic and the RX FIFO/register interface; presents words through a one-entry valid/ready output buffer.
- Flushes partial words on stop and reports overflow when the consumer stalls.

---
 rtl/qspi_rx_deser.sv | 128 ++++++++++++
 tb/tb_qspi_rx_deser.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_rx_deser.sv
// QSPI receive deserialiser: packs x1/x2/x4 lane samples (MSB- or LSB-first) into DATA_W words, flushes partials on stop.
// Word appears one cycle after its completing sample; one-entry valid/ready buffer drops new words and flags overflow while stalled.
module qspi_rx_deser #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        sd_i,
  input  logic              sample_en_i,
  input  logic [1:0]        mode_i,
  input  logic              lsb_first_i,
  input  logic              start_i,
  input  logic              stop_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  data_bits_o,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic              busy_o,
  output logic              overflow_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

  state_t            state_q;
  logic [1:0]        mode_q;
  logic              lsb_q;
  logic [DATA_W-1:0] sr_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [CNT_W-1:0]  lanes;
  logic [DATA_W-1:0] sr_smp;
  logic [DATA_W-1:0] sr_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              word_done;
  logic [DATA_W-1:0] flush_dat;
  logic [DATA_W-1:0] emit_dat;
  logic              emit;

  // Reserved mode 11 falls into the default single-lane arm.
  always_comb begin
    lanes  = CNT_W'(1);
    sr_smp = sr_q;
    case (mode_q)
      2'b01: begin
        lanes  = CNT_W'(2);
        sr_smp = lsb_q ? {sd_i[1:0], sr_q[DATA_W-1:2]} : {sr_q[DATA_W-3:0], sd_i[1:0]};
      end
      2'b10: begin
        lanes  = CNT_W'(4);
        sr_smp = lsb_q ? {sd_i[3:0], sr_q[DATA_W-1:4]} : {sr_q[DATA_W-5:0], sd_i[3:0]};
      end
      default: begin
        lanes  = CNT_W'(1);
        sr_smp = lsb_q ? {sd_i[1], sr_q[DATA_W-1:1]} : {sr_q[DATA_W-2:0], sd_i[1]};
      end
    endcase
  end

  // A sample arriving with stop is folded in before the flush decision.
  always_comb begin
    sr_nxt    = sample_en_i ? sr_smp : sr_q;
    cnt_nxt   = sample_en_i ? cnt_q + lanes : cnt_q;
    word_done = sample_en_i && (cnt_nxt == FULL);
    flush_dat = lsb_q ? (sr_nxt >> (FULL - cnt_nxt)) : sr_nxt;
    emit_dat  = word_done ? sr_nxt : flush_dat;
    emit      = (state_q == SHIFT) && !start_i &&
                (word_done || (stop_i && (cnt_nxt != '0)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      mode_q       <= 2'b00;
      lsb_q        <= 1'b0;
      sr_q         <= '0;
      cnt_q        <= '0;
      data_o       <= '0;
      data_bits_o  <= '0;
      data_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      if (data_valid_o && data_ready_i) begin
        data_valid_o <= 1'b0;
      end
      if (emit) begin
        if (!data_valid_o || data_ready_i) begin
          data_o       <= emit_dat;
          data_bits_o  <= cnt_nxt;
          data_valid_o <= 1'b1;
        end else begin
          overflow_o <= 1'b1;
        end
      end

      // start takes priority over stop and restarts from either state.
      if (start_i) begin
        state_q    <= SHIFT;
        busy_o     <= 1'b1;
        mode_q     <= mode_i;
        lsb_q      <= lsb_first_i;
        sr_q       <= '0;
        cnt_q      <= '0;
        overflow_o <= 1'b0;
      end else if (state_q == SHIFT) begin
        if (stop_i) begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
          sr_q    <= '0;
          cnt_q   <= '0;
        end else if (word_done) begin
          sr_q  <= '0;
          cnt_q <= '0;
        end else if (sample_en_i) begin
          sr_q  <= sr_nxt;
          cnt_q <= cnt_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_qspi_rx_deser.sv
// Bench for qspi_rx_deser: vector table plus corner-case sequences, words checked through a scoreboard queue.
module tb_qspi_rx_deser;
  localparam int DW = 32;
  localparam int CW = $clog2(DW + 1);

  logic          clk = 1'b0;
  logic          rst_i;
  logic [3:0]    sd_i;
  logic          sample_en_i;
  logic [1:0]    mode_i;
  logic          lsb_first_i;
  logic          start_i;
  logic          stop_i;
  logic [DW-1:0] data_o;
  logic [CW-1:0] data_bits_o;
  logic          data_valid_o;
  logic          data_ready_i;
  logic          busy_o;
  logic          overflow_o;

  always #5 clk = ~clk;

  qspi_rx_deser #(.DATA_W(DW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .sd_i         (sd_i),
    .sample_en_i  (sample_en_i),
    .mode_i       (mode_i),
    .lsb_first_i  (lsb_first_i),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .data_o       (data_o),
    .data_bits_o  (data_bits_o),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .busy_o       (busy_o),
    .overflow_o   (overflow_o)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] b;
  } word_t;

  typedef struct {
    logic [1:0]    mode;
    logic          lsb;
    int            n;
    logic [63:0]   nib;
    logic          stop;
    logic [DW-1:0] d;
    logic [CW-1:0] b;
  } vec_t;

  word_t sb[$];
  vec_t  vecs[9];
  int    errors = 0;
  int    checks = 0;
  int    pushed = 0;
  int    seen   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [CW-1:0] b);
    word_t w;
    w.d = d;
    w.b = b;
    sb.push_back(w);
    pushed++;
  endtask

  task automatic samp(input logic [3:0] v);
    sd_i        = v;
    sample_en_i = 1'b1;
    tick();
    sample_en_i = 1'b0;
  endtask

  task automatic arm(input logic [1:0] m, input logic l);
    mode_i      = m;
    lsb_first_i = l;
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
  endtask

  function automatic vec_t mk(input logic [1:0] m, input logic l, input int n, input logic [63:0] nib,
                              input logic stp, input logic [DW-1:0] d, input logic [CW-1:0] b);
    vec_t v;
    v.mode = m; v.lsb = l; v.n = n; v.nib = nib; v.stop = stp; v.d = d; v.b = b;
    return v;
  endfunction

  // Consumer side: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_i && data_valid_o && data_ready_i) begin
      seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got data=0x%0h bits=%0d, expected no word", data_o, data_bits_o);
      end else begin
        word_t w;
        w = sb.pop_front();
        chk("word_data", data_o, w.d);
        chk("word_bits", data_bits_o, w.b);
      end
    end
  end

  initial begin
    vecs[0] = mk(2'b10, 1'b0,  8, 64'h1234_5678_0000_0000, 1'b0, 32'h1234_5678, 6'd32);
    vecs[1] = mk(2'b10, 1'b1,  8, 64'h1234_5678_0000_0000, 1'b0, 32'h8765_4321, 6'd32);
    vecs[2] = mk(2'b01, 1'b0, 16, 64'h2121_2121_2121_2121, 1'b0, 32'h9999_9999, 6'd32);
    vecs[3] = mk(2'b00, 1'b0,  8, 64'h2020_0202_0000_0000, 1'b1, 32'h0000_00A5, 6'd8);
    vecs[4] = mk(2'b10, 1'b1,  3, 64'h1230_0000_0000_0000, 1'b1, 32'h0000_0321, 6'd12);
    vecs[5] = mk(2'b10, 1'b0,  3, 64'hABC0_0000_0000_0000, 1'b1, 32'h0000_0ABC, 6'd12);
    vecs[6] = mk(2'b01, 1'b1,  4, 64'h1230_0000_0000_0000, 1'b1, 32'h0000_0039, 6'd8);
    vecs[7] = mk(2'b00, 1'b1,  8, 64'h2200_0000_0000_0000, 1'b1, 32'h0000_0003, 6'd8);
    vecs[8] = mk(2'b11, 1'b0,  4, 64'hD22D_0000_0000_0000, 1'b1, 32'h0000_0006, 6'd4);

    rst_i = 1'b1; sd_i = 4'h0; sample_en_i = 1'b0; mode_i = 2'b00; lsb_first_i = 1'b0;
    start_i = 1'b0; stop_i = 1'b0; data_ready_i = 1'b1;
    tick();
    tick();
    chk("rst_data", data_o, 0);
    chk("rst_bits", data_bits_o, 0);
    chk("rst_valid", data_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovf", overflow_o, 0);
    rst_i = 1'b0;
    tick();

    for (int v = 0; v < 9; v++) begin
      arm(vecs[v].mode, vecs[v].lsb);
      chk("vec_busy_armed", busy_o, 1);
      for (int i = 0; i < vecs[v].n; i++) begin
        if (i == vecs[v].n - 1 && !vecs[v].stop) push(vecs[v].d, vecs[v].b);
        samp(vecs[v].nib[63-4*i -: 4]);
      end
      if (vecs[v].stop) begin
        push(vecs[v].d, vecs[v].b);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
      end
      chk("vec_valid_hi", data_valid_o, 1);
      chk("vec_busy_end", busy_o, !vecs[v].stop);
      tick();
      chk("vec_valid_one_cycle", data_valid_o, 0);
    end

    // Stop with nothing collected emits no word.
    arm(2'b10, 1'b0);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    chk("empty_stop_busy", busy_o, 0);
    chk("empty_stop_valid", data_valid_o, 0);
    samp(4'hF);
    chk("idle_sample_ignored", data_valid_o, 0);

    // Completing sample together with stop: one full word, no trailing empty flush.
    arm(2'b10, 1'b0);
    for (int i = 1; i <= 7; i++) samp(4'(i));
    push(32'h1234_5678, 6'd32);
    sd_i = 4'h8; sample_en_i = 1'b1; stop_i = 1'b1;
    tick();
    sample_en_i = 1'b0; stop_i = 1'b0;
    chk("smp_stop_valid", data_valid_o, 1);
    chk("smp_stop_busy", busy_o, 0);
    tick();
    chk("smp_stop_no_extra", data_valid_o, 0);

    // Partial sample together with stop: the sample is included in the flush.
    arm(2'b10, 1'b0);
    samp(4'h1);
    samp(4'h2);
    push(32'h0000_0123, 6'd12);
    sd_i = 4'h3; sample_en_i = 1'b1; stop_i = 1'b1;
    tick();
    sample_en_i = 1'b0; stop_i = 1'b0;
    chk("part_stop_valid", data_valid_o, 1);
    tick();

    // start and stop together: start wins, partial word discarded.
    arm(2'b10, 1'b0);
    samp(4'h5);
    samp(4'h5);
    start_i = 1'b1; stop_i = 1'b1;
    tick();
    start_i = 1'b0; stop_i = 1'b0;
    chk("start_stop_busy", busy_o, 1);
    chk("start_stop_valid", data_valid_o, 0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) push(32'h1234_5678, 6'd32);
      samp(4'(i));
    end
    chk("restart_word_valid", data_valid_o, 1);
    tick();

    // mode/order changes after start are ignored.
    arm(2'b10, 1'b0);
    mode_i = 2'b00; lsb_first_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) push(32'h1234_5678, 6'd32);
      samp(4'(i));
    end
    chk("latched_mode_valid", data_valid_o, 1);
    tick();

    // Overflow with a stalled consumer.
    data_ready_i = 1'b0;
    arm(2'b10, 1'b0);
    for (int i = 0; i < 16; i++) samp(4'hF);
    for (int i = 0; i < 16; i++) samp(4'h0);
    chk("ovf_data_kept", data_o, 32'hFFFF_FFFF);
    chk("ovf_bits", data_bits_o, 32);
    chk("ovf_valid", data_valid_o, 1);
    chk("ovf_flag", overflow_o, 1);
    push(32'hFFFF_FFFF, 6'd32);
    data_ready_i = 1'b1;
    tick();
    chk("ovf_drained", data_valid_o, 0);
    chk("ovf_sticky", overflow_o, 1);
    arm(2'b10, 1'b0);
    chk("ovf_cleared_by_start", overflow_o, 0);

    // Reset mid-word leaves no residue.
    samp(4'h9);
    samp(4'hA);
    samp(4'hB);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("midrst_data", data_o, 0);
    chk("midrst_bits", data_bits_o, 0);
    chk("midrst_valid", data_valid_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ovf", overflow_o, 0);
    arm(2'b10, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) push(32'h1234_5678, 6'd32);
      samp(4'(i));
    end
    chk("postrst_valid", data_valid_o, 1);
    tick();
    tick();

    chk("sb_drained", sb.size(), 0);
    chk("word_count", seen, pushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
